// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide sequencer that owns the HI/LO registers.
// It runs mult/multu as radix-2 shift-add and div/divu as restoring
// shift-subtract, producing one bit per RUN cycle.
// Optional feature macro: MDU_EARLY_OUT_EN. When it is defined, a multiply
// leaves RUN as soon as the remaining multiplier bits are all zero.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_nxt, prod;   // {hi half, lo half} working register
    logic [WIDTH-1:0]   opnd;                 // multiplicand or divisor magnitude
    logic               is_div, sgn_q, sgn_r;
    logic               launch, go_fix, early;
    logic [WIDTH-1:0]   a_mag, b_mag, res_hi, res_lo;
    logic [WIDTH:0]     sum, rsh, diff;

    // A start is only accepted while the sequencer is idle or finishing.
    assign launch = start && (state == IDLE || state == DONE);
    // Signed ops work on magnitudes; the signs are reapplied in FIX.
    assign a_mag  = (op[0] && a[WIDTH-1]) ? -a : a;
    assign b_mag  = (op[0] && b[WIDTH-1]) ? -b : b;

    // Launches that need no iteration go straight to FIX.
`ifdef MDU_EARLY_OUT_EN
    assign go_fix = (b == '0);
`else
    assign go_fix = op[1] && (b == '0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = launch ? (go_fix ? FIX : RUN) : IDLE;
            RUN:        if (cnt == '0 || early) state_nxt = FIX;
            FIX:        state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Status outputs are decoded from the state.
    always_comb begin
        busy = (state == RUN) || (state == FIX);
        done = (state == DONE);
    end

    // One iteration step and the sign-corrected result.
    always_comb begin
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        rsh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff = rsh - {1'b0, opnd};
        if (is_div)
            acc_nxt = diff[WIDTH] ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_nxt = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        early = 1'b0;
        prod  = acc;
`ifdef MDU_EARLY_OUT_EN
        // cnt low bits of acc_nxt are the multiplier bits not yet consumed.
        early = !is_div && ((acc_nxt[WIDTH-1:0] & ~({WIDTH{1'b1}} << cnt)) == '0);
        // cnt holds the skipped shifts (zero after a full-length run).
        prod  = acc >> cnt;
`endif
        if (sgn_q) prod = -prod;
        if (is_div) begin
            res_lo = sgn_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            res_hi = sgn_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else begin
            res_lo = prod[WIDTH-1:0];
            res_hi = prod[2*WIDTH-1:WIDTH];
        end
    end

    // Operand latch at launch, then one iteration per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            sgn_q  <= 1'b0;
            sgn_r  <= 1'b0;
        end else if (launch) begin
            cnt    <= CW'(WIDTH - 1);
            is_div <= op[1];
            opnd   <= op[1] ? b_mag : a_mag;
            if (op[1] && b == '0) begin
                // Divide by zero: hi = raw dividend, lo = all ones, no sign fix.
                acc   <= {a, {WIDTH{1'b1}}};
                sgn_q <= 1'b0;
                sgn_r <= 1'b0;
            end else begin
                acc   <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                sgn_q <= op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
                sgn_r <= op[0] && op[1] && a[WIDTH-1];
            end
        end else if (state == RUN) begin
            acc <= acc_nxt;
            if (state_nxt == RUN) cnt <= cnt - CW'(1);
        end
    end

    // HI/LO: the result is written in FIX; mthi/mtlo only apply while not busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (state == IDLE || state == DONE) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end
endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative multiply/divide sequencer for the 36-instruction MIPS core; it executes mult, multu, div and divu and owns the HI/LO registers. It sits beside the main ALU in the execute stage. The pipeline launches an operation with a one-cycle start pulse and stalls on busy until done, so the ALU keeps its single-cycle function-code decode path. mthi/mtlo writes and mfhi/mflo reads go through this block.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch pulse; sampled only in IDLE or DONE.
- op  input  2  operation select: 00 multu, 01 mult, 10 divu, 11 div.
- a  input  WIDTH  rs operand (multiplicand or dividend); sampled with start.
- b  input  WIDTH  rt operand (multiplier or divisor); sampled with start.
- hi_we  input  1  mthi write strobe.
- lo_we  input  1  mtlo write strobe.
- wdata  input  WIDTH  mthi/mtlo data.
- busy  output  1  operation in flight; the pipeline stalls while it is high.
- done  output  1  one-cycle pulse; HI/LO hold the new result from this cycle.
- hi  output  WIDTH  HI register (registered).
- lo  output  WIDTH  LO register (registered).
- Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
- Reset values: state IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0.
- Signed operations (mult, div):
  - operands are replaced by their magnitudes at launch;
  - result sign flags are latched at launch: product sign = a[MSB]^b[MSB]; quotient sign = a[MSB]^b[MSB]; remainder sign = a[MSB].
- Unsigned operations (multu, divu) use the operands unchanged.
- Multiply: radix-2 shift-add, one multiplier bit per RUN cycle, over a 2×WIDTH accumulator.
- Divide: restoring shift-subtract, one quotient bit per RUN cycle.
- IDLE/DONE + start=1 → RUN. The counter loads WIDTH-1, and the operands and flags are latched.
- RUN: one iteration per cycle. The counter decrements; counter==0 in RUN → FIX.
- FIX: apply two's-complement sign correction; write results: mult → {hi,lo} = product; div → lo = quotient, hi = remainder. Then → DONE.
- DONE: done=1 for exactly one cycle. Then → IDLE, or → RUN if start=1 in that cycle (back-to-back launch).
- busy=1 in RUN and FIX only.
- start while busy=1 is ignored; no queuing.
- hi_we/lo_we:
  - applied at the next edge when state is IDLE or DONE;
  - dropped while busy=1;
  - if they coincide with an accepted start, the write is applied and later overwritten by the result.
- Divide by zero (div/divu with b==0):
  - the launch goes directly to FIX with no RUN cycles;
  - result is hi = a (raw), lo = all ones.
- div overflow (a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0; this is the natural result of the magnitude algorithm and needs no trap.
- Signed division truncates toward zero; the remainder takes the dividend's sign.
- Reset mid-operation aborts immediately: state IDLE, HI/LO cleared, no done pulse.

## Timing
- start is sampled at edge E0.
- Normal operation:
  - busy is high in the cycles following E0 … E32 (WIDTH+1 = 33 cycles: 32 RUN + 1 FIX);
  - HI/LO update and done rises at edge E33;
  - done falls at E34.
- Divide by zero: busy is high for 1 cycle (FIX); HI/LO update and done rises at E1.
- Back-to-back: start during the DONE cycle gives busy=1 in the very next cycle, with no idle bubble.
- hi/lo are register outputs with no combinational path from any input.

## Configuration
- MDU_EARLY_OUT_EN defined:
  - multiply leaves RUN for FIX as soon as the remaining unshifted multiplier bits are all zero; the accumulator is aligned by the remaining shift count in FIX;
  - minimum multiply latency is 1 RUN cycle + FIX (e.g. b=1 → done at E2; b=0 → done at E1 via direct FIX);
  - divide latency is unchanged.
- MDU_EARLY_OUT_EN undefined: fixed latency, with done at E33 for every non-zero-divisor operation.

## Test plan
- Reset: check hi=0, lo=0, busy=0, done=0. Then multu a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly at E33, single cycle.
- mult a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- div a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- divu a=0x12345678, b=0 → done at E1, hi=0x12345678, lo=0xFFFFFFFF.
- Concurrency and reset:
  - mthi 0xA5A5A5A5 while busy → dropped;
  - start pulsed during busy → ignored;
  - start in the DONE cycle → second result at E33 relative to that start;
  - rst asserted at E10 of a divu → IDLE, hi=lo=0, no done pulse.
